// File: rtl/spi_frame_tx.sv
// SPI master transmitter: one 24-bit frame (command, databyte1, databyte2),
// CPOL=0 / CPHA=0, MSB first, cs active-high around the whole frame.
//
// state | meaning
// IDLE  | ready for start, all lines low
// SETUP | cs high, first bit on sdo, waiting out one half-period before sck rises
// HIGH  | sck high, receiver samples sdo
// LOW   | sck low, next bit presented (or cs hold after the last bit)
// GAP   | cs low, guaranteed minimum spacing before the next frame
module spi_frame_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] command,
  input  logic [7:0] databyte1,
  input  logic [7:0] databyte2,
  output logic       ready,
  output logic       done,
  output logic       sck,
  output logic       sdo,
  output logic       cs
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] HIGH  = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]    state;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   shreg;
  logic          div_tc;

  assign div_tc = (div_cnt == '0);

  // sdo is the shift register MSB, so it is a flop output; zeros shifted in
  // leave sdo low once the 24th bit has gone out.
  assign sdo = shreg[23];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      sck     <= 1'b0;
      cs      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            shreg   <= {command, databyte1, databyte2};
            cs      <= 1'b1;
            ready   <= 1'b0;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
          end
        end
        SETUP: begin
          if (div_tc) begin
            state   <= HIGH;
            sck     <= 1'b1;
            div_cnt <= DIV_LOAD;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        HIGH: begin
          if (div_tc) begin
            state   <= LOW;
            sck     <= 1'b0;
            shreg   <= {shreg[22:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            div_cnt <= DIV_LOAD;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        LOW: begin
          if (div_tc) begin
            div_cnt <= DIV_LOAD;
            if (bit_cnt == 5'd24) begin
              state <= GAP;
              cs    <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= HIGH;
              sck   <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        GAP: begin
          if (div_tc) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          sck   <= 1'b0;
          cs    <= 1'b0;
          shreg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx at CLK_DIV = 2, 1 and 7: stimulus queues
// expected frames and line snapshots, one monitor decodes the bus and compares.
module tb_spi_frame_tx;

  typedef struct {
    logic [23:0] data;
    int          acc;
    bit          abort;
    int          rises;
  } frame_t;

  typedef struct {
    int   inst;
    int   at;
    logic cs, sck, sdo, ready, done;
  } snap_t;

  logic clk = 1'b0;
  int   cyc = 0;

  logic       rst_s   [3];
  logic       start_s [3];
  logic [7:0] cmd_s   [3];
  logic [7:0] d1_s    [3];
  logic [7:0] d2_s    [3];
  logic       ready_w [3];
  logic       done_w  [3];
  logic       sck_w   [3];
  logic       sdo_w   [3];
  logic       cs_w    [3];

  frame_t q [3][$];
  snap_t  snap_q[$];
  int     exp_done [3];
  int     n_done   [3];
  int     n_vec = 0;
  int     n_err = 0;
  bit     end_req = 1'b0;
  bit     end_ack = 1'b0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : u
    spi_frame_tx #(.CLK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 7))) dut (
      .clk      (clk),
      .reset    (rst_s[g]),
      .start    (start_s[g]),
      .command  (cmd_s[g]),
      .databyte1(d1_s[g]),
      .databyte2(d2_s[g]),
      .ready    (ready_w[g]),
      .done     (done_w[g]),
      .sck      (sck_w[g]),
      .sdo      (sdo_w[g]),
      .cs       (cs_w[g])
    );
  end

  function automatic int div_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 7);
  endfunction

  task automatic chk(string name, int g, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL div%0d %s: got %0d expected %0d (cycle %0d)", div_of(g), name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        pcs  [3] = '{default: 1'b0};
  logic        psck [3] = '{default: 1'b0};
  logic        lsdo [3] = '{default: 1'b0};
  logic [23:0] sh   [3] = '{default: 24'h0};
  int          rises[3], hi[3], ph[3], fall_cyc[3];
  bit          have_fall[3], duty_bad[3], stab_bad[3], out_bad[3], tail_bad[3];

  initial begin
    frame_t e;
    snap_t  s;
    int     d;
    forever begin
      @(negedge clk);
      while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
        s = snap_q.pop_front();
        chk("snap_cs",    s.inst, int'(cs_w[s.inst]),    int'(s.cs));
        chk("snap_sck",   s.inst, int'(sck_w[s.inst]),   int'(s.sck));
        chk("snap_sdo",   s.inst, int'(sdo_w[s.inst]),   int'(s.sdo));
        chk("snap_ready", s.inst, int'(ready_w[s.inst]), int'(s.ready));
        chk("snap_done",  s.inst, int'(done_w[s.inst]),  int'(s.done));
      end
      for (int g = 0; g < 3; g++) begin
        d = div_of(g);
        if (done_w[g]) n_done[g]++;
        if (done_w[g] && !(pcs[g] && !cs_w[g])) chk("stray_done", g, 1, 0);
        if (cs_w[g] && !pcs[g]) begin
          if (have_fall[g]) chk("cs_low_time", g, int'(cyc - fall_cyc[g] >= d + 1), 1);
          sh[g] = '0; rises[g] = 0; hi[g] = 0; ph[g] = 0;
          duty_bad[g] = 0; stab_bad[g] = 0; out_bad[g] = 0; tail_bad[g] = 0;
        end
        if (cs_w[g]) hi[g]++;
        if (sck_w[g] && !psck[g]) begin
          if (!cs_w[g]) out_bad[g] = 1;
          else begin
            if (ph[g] != d) duty_bad[g] = 1;
            sh[g] = {sh[g][22:0], sdo_w[g]};
            rises[g]++;
            lsdo[g] = sdo_w[g];
          end
          ph[g] = 1;
        end else if (!sck_w[g] && psck[g]) begin
          if (ph[g] != d) duty_bad[g] = 1;
          ph[g] = 1;
        end else begin
          ph[g]++;
        end
        if (sck_w[g] && cs_w[g] && sdo_w[g] !== lsdo[g]) stab_bad[g] = 1;
        if (cs_w[g] && !sck_w[g] && rises[g] == 24 && sdo_w[g]) tail_bad[g] = 1;
        if (pcs[g] && !cs_w[g]) begin
          if (q[g].size() == 0) chk("unexpected_frame", g, 1, 0);
          else begin
            e = q[g].pop_front();
            if (e.abort) begin
              chk("abort_no_done", g, int'(done_w[g]), 0);
              chk("abort_rises", g, rises[g], e.rises);
              have_fall[g] = 0;
            end else begin
              chk("rx_data", g, int'(sh[g]), int'(e.data));
              chk("sck_rises", g, rises[g], 24);
              chk("cs_high_cycles", g, hi[g], 49 * d);
              chk("accept_to_done", g, cyc - e.acc, 49 * d + 1);
              chk("done_at_cs_fall", g, int'(done_w[g]), 1);
              chk("sck_duty", g, int'(duty_bad[g]), 0);
              chk("sdo_stable_high", g, int'(stab_bad[g]), 0);
              chk("sdo_tail_zero", g, int'(tail_bad[g] | sdo_w[g]), 0);
              chk("sck_outside_cs", g, int'(out_bad[g]), 0);
              have_fall[g] = 1;
              fall_cyc[g]  = cyc;
            end
          end
        end
        pcs[g]  = cs_w[g];
        psck[g] = sck_w[g];
      end
      if (end_req && !end_ack) begin
        for (int g = 0; g < 3; g++) begin
          chk("frames_pending", g, q[g].size(), 0);
          chk("done_count", g, n_done[g], exp_done[g]);
        end
        end_ack = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_frame(int i, logic [23:0] data, int acc, bit abort, int r);
    frame_t f;
    f.data = data; f.acc = acc; f.abort = abort; f.rises = r;
    q[i].push_back(f);
    if (!abort) exp_done[i]++;
  endtask

  task automatic set_data(int i, logic [7:0] c, logic [7:0] a, logic [7:0] b);
    cmd_s[i] = c; d1_s[i] = a; d2_s[i] = b;
  endtask

  // called on a negedge with the DUT known idle; returns one cycle later
  task automatic send(int i, logic [7:0] c, logic [7:0] a, logic [7:0] b,
                      bit abort, int r, output int acc);
    start_s[i] = 1'b1;
    set_data(i, c, a, b);
    acc = cyc;
    push_frame(i, {c, a, b}, acc, abort, r);
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic expect_idle(int i, int at);
    snap_t s;
    s.inst = i; s.at = at;
    s.cs = 1'b0; s.sck = 1'b0; s.sdo = 1'b0; s.ready = 1'b1; s.done = 1'b0;
    snap_q.push_back(s);
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int acc, acc2;
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b0;
      set_data(i, 8'h00, 8'h00, 8'h00);
      expect_idle(i, 2);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
    @(negedge clk);

    // basic frame, then an ignored start and input churn mid-frame
    send(0, 8'h03, 8'h18, 8'h09, 1'b0, 24, acc);
    wait_until(acc + 20);
    start_s[0] = 1'b1;
    set_data(0, 8'hFF, 8'hFF, 8'hFF);
    @(negedge clk);
    start_s[0] = 1'b0;
    set_data(0, 8'h55, 8'h66, 8'h77);
    wait_until(acc + 120);

    // start held high: second accept lands 50*2+1 cycles after the first
    start_s[0] = 1'b1;
    set_data(0, 8'hA5, 8'h5A, 8'hC3);
    acc = cyc;
    push_frame(0, 24'hA55AC3, acc, 1'b0, 24);
    push_frame(0, 24'h00817E, acc + 101, 1'b0, 24);
    @(negedge clk);
    set_data(0, 8'h00, 8'h81, 8'h7E);
    wait_until(acc + 101);
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_until(acc + 101 + 120);

    // reset right after the 10th sck rise (visible at acc+3+4*9)
    send(0, 8'hC3, 8'h3C, 8'h99, 1'b1, 10, acc);
    wait_until(acc + 39);
    rst_s[0] = 1'b1;
    expect_idle(0, acc + 40);
    @(negedge clk);
    rst_s[0] = 1'b0;

    // reset and start together: reset wins
    @(negedge clk);
    rst_s[0] = 1'b1; start_s[0] = 1'b1;
    set_data(0, 8'hFF, 8'hFF, 8'hFF);
    acc2 = cyc;
    expect_idle(0, acc2 + 1);
    expect_idle(0, acc2 + 4);
    @(negedge clk);
    rst_s[0] = 1'b0; start_s[0] = 1'b0;
    wait_until(acc2 + 6);
    send(0, 8'h12, 8'h34, 8'h56, 1'b0, 24, acc);
    wait_until(acc + 120);

    // divider extremes
    send(1, 8'h80, 8'h01, 8'hAA, 1'b0, 24, acc);
    wait_until(acc + 60);
    send(2, 8'h80, 8'h01, 8'hAA, 1'b0, 24, acc);
    wait_until(acc + 7 * 50 + 10);

    end_req = 1'b1;
    for (int k = 0; k < 4 && !end_ack; k++) @(negedge clk);
    if (!end_ack) begin
      $display("FAIL end_handshake: monitor did not respond, got 0 expected 1");
      $fatal(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
